smart_home_ctrl_p: RTL
======================

// Module: smart_home_ctrl_p
// PURPOSE
//  Parametrised successor of the home-monitor controller. Debounces door, window and fire sensors.
//  Priority-encodes them into a registered status state.
//  Drives the door/buzzer indicators and the 3-bit display.
//  Runs heater/cooler from ST with a hysteresis band, minimum-run protection and a latched fire alarm cleared by ack.
// PARAMETERS
//  TEMP_W    7  width of ST (unsigned)
//  HEAT_ON   15 heater switches on when ST < HEAT_ON
//  HEAT_OFF  20 heater may switch off when ST >= HEAT_OFF
//  COOL_OFF  25 cooler may switch off when ST <= COOL_OFF
//  COOL_ON   30 cooler switches on when ST > COOL_ON
//               required ordering: HEAT_ON <= HEAT_OFF < COOL_OFF <= COOL_ON
//  DEB_CYC   4  consecutive stable cycles before a debounced sensor changes (>=1)
//  MIN_RUN   8  minimum cycles heater/cooler stays on once switched on (>=1)
//  FIRE_FIRST 0 1: SFA highest priority; 0: order SFD > SRD > SW > SFA
// PORTS
//  clk        in  1      system clock, rising edge
//  Rst        in  1      asynchronous, active-low reset
//  SFD        in  1      front-door sensor, raw, async
//  SRD        in  1      rear-door sensor, raw, async
//  SW         in  1      window sensor, raw, async
//  SFA        in  1      fire sensor, raw, async
//  alarm_ack  in  1      fire-alarm acknowledge, synchronous level
//  ST         in  TEMP_W temperature sample, synchronous to clk
//  fdoor      out 1      high in state FDOOR
//  rdoor      out 1      high in state RDOOR
//  winbuzz    out 1      high in state WIN
//  alarmbuzz  out 1      high in state ALARM
//  heater     out 1      registered heater enable
//  cooler     out 1      registered cooler enable
//  display    out 3      current state code
// BEHAVIOUR
//  Reset (Rst=0, async): state=IDLE, all outputs 0, sync/debounce flops 0, counters 0.
//  Input conditioning:
//   - Each sensor: 2-FF synchroniser, then a debounce counter.
//   - Debounced value takes the synced value after DEB_CYC consecutive cycles of disagreement.
//   - Counter clears on any agreeing cycle.
//  States and display codes:
//   IDLE=000, FDOOR=001, RDOOR=010, ALARM=011, WIN=100, CLIMATE=101. 110/111 unused; treated as IDLE next cycle.
//  Next-state rules:
//   - Highest-priority debounced active sensor selects FDOOR/RDOOR/WIN/ALARM per FIRE_FIRST.
//   - With no sensor active: CLIMATE if heater|cooler, else IDLE.
//   - ALARM is latched: exit only in a cycle with alarm_ack=1 and debounced SFA=0.
//     Exit goes to the normally computed state. While latched, other sensors are ignored.
//  Indicator outputs: decoded from the state register, valid the cycle after the state update.
//  Sensor latency: raw edge to state change = 2 + DEB_CYC + 1 cycles.
//  Climate control (registered, compares unsigned):
//   - heater on: heater=0, cooler=0, ST < HEAT_ON. run_cnt reloads to 0.
//   - heater off: heater=1, ST >= HEAT_OFF, run_cnt >= MIN_RUN-1.
//   - Cooler is symmetric: on when ST > COOL_ON, off when ST <= COOL_OFF and run_cnt >= MIN_RUN-1.
//   - heater and cooler are never both 1. Inside the band the current value is held.
//   - run_cnt saturates at MIN_RUN-1.
//   - In ALARM both are forced 0 next cycle, regardless of MIN_RUN.
//     Re-enable after exit follows the normal rules.
//  Simultaneous events:
//   - alarm_ack with SFA still debounced-high: ignored.
//   - Sensors changing in the same cycle resolve by priority only.
//  Mid-operation reset: all state lost immediately, including a latched ALARM and run_cnt.
// TESTING
//  1. Rst=0 then release, ST=22, no sensors -> all outputs 0, display=000 for 20 cycles.
//  2. SFD pulse 2 cycles (DEB_CYC=4) -> no change.
//     SFD held -> fdoor=1, display=001 exactly 7 cycles after the edge.
//  3. SRD and SW high together (FIRE_FIRST=0) -> RDOOR/010.
//     Drop SRD -> WIN/100 after 7 cycles.
//  4. SFA held 10 cycles then low, alarm_ack=0 -> ALARM/011 stays, alarmbuzz=1.
//     alarm_ack=1 -> IDLE next cycle.
//     Repeat with SFA still high -> remains ALARM.
//  5. ST=10 -> heater=1, display=101. ST=25 two cycles later -> heater held until 8 cycles on.
//     ST=17 -> heater held. ST=40 -> cooler=1 only after heater=0.
//  6. Cooler on, SFA asserted -> cooler=0 in the cycle after ALARM is entered.
//     Assert Rst mid-ALARM -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/smart_home_ctrl_p.sv
// Home-monitor controller: synchronised and debounced door/window/fire sensors feed a priority
// status FSM; a hysteresis climate loop with minimum-run protection drives heater and cooler.
module smart_home_ctrl_p #(
  parameter int TEMP_W     = 7,
  parameter int HEAT_ON    = 15,
  parameter int HEAT_OFF   = 20,
  parameter int COOL_OFF   = 25,
  parameter int COOL_ON    = 30,
  parameter int DEB_CYC    = 4,
  parameter int MIN_RUN    = 8,
  parameter int FIRE_FIRST = 0
) (
  input  logic              clk,
  input  logic              Rst,
  input  logic              SFD,
  input  logic              SRD,
  input  logic              SW,
  input  logic              SFA,
  input  logic              alarm_ack,
  input  logic [TEMP_W-1:0] ST,
  output logic              fdoor,
  output logic              rdoor,
  output logic              winbuzz,
  output logic              alarmbuzz,
  output logic              heater,
  output logic              cooler,
  output logic [2:0]        display
);

  localparam int DEB_W = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
  localparam int RUN_W = (MIN_RUN > 1) ? $clog2(MIN_RUN) : 1;
  localparam logic [DEB_W-1:0]  DEB_MAX    = DEB_W'(DEB_CYC - 1);
  localparam logic [RUN_W-1:0]  RUN_MAX    = RUN_W'(MIN_RUN - 1);
  localparam logic [TEMP_W-1:0] HEAT_ON_T  = TEMP_W'(HEAT_ON);
  localparam logic [TEMP_W-1:0] HEAT_OFF_T = TEMP_W'(HEAT_OFF);
  localparam logic [TEMP_W-1:0] COOL_OFF_T = TEMP_W'(COOL_OFF);
  localparam logic [TEMP_W-1:0] COOL_ON_T  = TEMP_W'(COOL_ON);

  typedef enum logic [2:0] {
    IDLE    = 3'b000,
    FDOOR   = 3'b001,
    RDOOR   = 3'b010,
    ALARM   = 3'b011,
    WIN     = 3'b100,
    CLIMATE = 3'b101
  } state_t;

  // Bit order of the sensor vectors: 0=SFD, 1=SRD, 2=SW, 3=SFA
  logic [3:0] raw_sens;
  logic [3:0] deb_sens;

  assign raw_sens = {SFA, SW, SRD, SFD};

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_sensor
      logic             sync1_reg;
      logic             sync2_reg;
      logic             deb_reg;
      logic [DEB_W-1:0] cnt_reg;

      always_ff @(posedge clk or negedge Rst) begin
        if (!Rst) begin
          sync1_reg <= 1'b0;
          sync2_reg <= 1'b0;
          deb_reg   <= 1'b0;
          cnt_reg   <= '0;
        end else begin
          sync1_reg <= raw_sens[gi];
          sync2_reg <= sync1_reg;
          // Any cycle that agrees with the debounced value restarts the count
          if (sync2_reg != deb_reg) begin
            if (cnt_reg == DEB_MAX) begin
              deb_reg <= sync2_reg;
              cnt_reg <= '0;
            end else begin
              cnt_reg <= cnt_reg + DEB_W'(1);
            end
          end else begin
            cnt_reg <= '0;
          end
        end
      end

      assign deb_sens[gi] = deb_reg;
    end
  endgenerate

  logic sfd_d, srd_d, sw_d, sfa_d;
  assign sfd_d = deb_sens[0];
  assign srd_d = deb_sens[1];
  assign sw_d  = deb_sens[2];
  assign sfa_d = deb_sens[3];

  state_t           state_reg, state_next, norm_state;
  logic             heater_reg, heater_next;
  logic             cooler_reg, cooler_next;
  logic [RUN_W-1:0] run_cnt_reg, run_cnt_next;

  always_comb begin
    norm_state = IDLE;
    if ((FIRE_FIRST != 0) && sfa_d) norm_state = ALARM;
    else if (sfd_d)                 norm_state = FDOOR;
    else if (srd_d)                 norm_state = RDOOR;
    else if (sw_d)                  norm_state = WIN;
    else if (sfa_d)                 norm_state = ALARM;
    else if (heater_reg || cooler_reg) norm_state = CLIMATE;
  end

  always_comb begin
    state_next = norm_state;
    case (state_reg)
      ALARM: begin
        // Latched until acknowledged with the fire sensor already quiet
        if (!(alarm_ack && !sfa_d)) state_next = ALARM;
      end
      IDLE, FDOOR, RDOOR, WIN, CLIMATE: ;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    heater_next  = heater_reg;
    cooler_next  = cooler_reg;
    run_cnt_next = run_cnt_reg;
    if (state_reg == ALARM) begin
      heater_next  = 1'b0;
      cooler_next  = 1'b0;
      run_cnt_next = '0;
    end else if (heater_reg) begin
      if ((ST >= HEAT_OFF_T) && (run_cnt_reg >= RUN_MAX)) heater_next = 1'b0;
      else if (run_cnt_reg != RUN_MAX) run_cnt_next = run_cnt_reg + RUN_W'(1);
    end else if (cooler_reg) begin
      if ((ST <= COOL_OFF_T) && (run_cnt_reg >= RUN_MAX)) cooler_next = 1'b0;
      else if (run_cnt_reg != RUN_MAX) run_cnt_next = run_cnt_reg + RUN_W'(1);
    end else if (ST < HEAT_ON_T) begin
      heater_next  = 1'b1;
      run_cnt_next = '0;
    end else if (ST > COOL_ON_T) begin
      cooler_next  = 1'b1;
      run_cnt_next = '0;
    end
  end

  always_ff @(posedge clk or negedge Rst) begin
    if (!Rst) begin
      state_reg   <= IDLE;
      heater_reg  <= 1'b0;
      cooler_reg  <= 1'b0;
      run_cnt_reg <= '0;
    end else begin
      state_reg   <= state_next;
      heater_reg  <= heater_next;
      cooler_reg  <= cooler_next;
      run_cnt_reg <= run_cnt_next;
    end
  end

  assign fdoor     = (state_reg == FDOOR);
  assign rdoor     = (state_reg == RDOOR);
  assign winbuzz   = (state_reg == WIN);
  assign alarmbuzz = (state_reg == ALARM);
  assign heater    = heater_reg;
  assign cooler    = cooler_reg;
  assign display   = state_reg;

endmodule
